// File: rtl/tl_a_client_arbiter.sv
// Two-client TileLink-UL A/D arbiter: round-robin A grants with beat locking,
// per-client in-flight limits, source tagging and tag-routed D responses.
module tl_a_client_arbiter #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in0_a_valid,
  output logic        in0_a_ready,
  input  logic [2:0]  in0_a_bits_opcode,
  input  logic [2:0]  in0_a_bits_param,
  input  logic [1:0]  in0_a_bits_size,
  input  logic [8:0]  in0_a_bits_source,
  input  logic [31:0] in0_a_bits_address,
  input  logic [7:0]  in0_a_bits_mask,
  input  logic [63:0] in0_a_bits_data,
  input  logic        in1_a_valid,
  output logic        in1_a_ready,
  input  logic [2:0]  in1_a_bits_opcode,
  input  logic [2:0]  in1_a_bits_param,
  input  logic [1:0]  in1_a_bits_size,
  input  logic [8:0]  in1_a_bits_source,
  input  logic [31:0] in1_a_bits_address,
  input  logic [7:0]  in1_a_bits_mask,
  input  logic [63:0] in1_a_bits_data,
  input  logic        in0_d_ready,
  output logic        in0_d_valid,
  output logic [2:0]  in0_d_bits_opcode,
  output logic [1:0]  in0_d_bits_param,
  output logic [1:0]  in0_d_bits_size,
  output logic [8:0]  in0_d_bits_source,
  output logic        in0_d_bits_sink,
  output logic        in0_d_bits_denied,
  output logic [63:0] in0_d_bits_data,
  output logic        in0_d_bits_corrupt,
  input  logic        in1_d_ready,
  output logic        in1_d_valid,
  output logic [2:0]  in1_d_bits_opcode,
  output logic [1:0]  in1_d_bits_param,
  output logic [1:0]  in1_d_bits_size,
  output logic [8:0]  in1_d_bits_source,
  output logic        in1_d_bits_sink,
  output logic        in1_d_bits_denied,
  output logic [63:0] in1_d_bits_data,
  output logic        in1_d_bits_corrupt,
  input  logic        out_a_ready,
  output logic        out_a_valid,
  output logic [2:0]  out_a_bits_opcode,
  output logic [2:0]  out_a_bits_param,
  output logic [1:0]  out_a_bits_size,
  output logic [9:0]  out_a_bits_source,
  output logic [31:0] out_a_bits_address,
  output logic [7:0]  out_a_bits_mask,
  output logic [63:0] out_a_bits_data,
  output logic        out_a_bits_corrupt,
  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_bits_opcode,
  input  logic [1:0]  out_d_bits_param,
  input  logic [1:0]  out_d_bits_size,
  input  logic [9:0]  out_d_bits_source,
  input  logic        out_d_bits_sink,
  input  logic        out_d_bits_denied,
  input  logic [63:0] out_d_bits_data,
  input  logic        out_d_bits_corrupt,
  input  logic        drain,
  output logic        idle,
  output logic        err_unexpected_d
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic             rr_ptr, locked, lock_idx, err_q;
  logic [CNT_W-1:0] inflight0, inflight1;
  logic             elig0, elig1, gnt, elig_gnt, a_fire;
  logic             a_fire0, a_fire1, d_fire0, d_fire1, tgt;

  // A locked grant keeps its beat eligible even while drain is high.
  assign elig0 = in0_a_valid & (inflight0 < MAX_CNT) & (~drain | (locked & ~lock_idx));
  assign elig1 = in1_a_valid & (inflight1 < MAX_CNT) & (~drain | (locked &  lock_idx));

  always_comb begin
    gnt = 1'b0;
    if (locked)              gnt = lock_idx;
    else if (elig0 && elig1) gnt = rr_ptr;
    else if (elig1)          gnt = 1'b1;
  end

  assign elig_gnt = gnt ? elig1 : elig0;

  // Handshake outputs are gated by reset so nothing is offered while held in reset.
  assign out_a_valid = reset & elig_gnt;
  assign in0_a_ready = reset & out_a_ready & ~gnt & elig0;
  assign in1_a_ready = reset & out_a_ready &  gnt & elig1;
  assign a_fire      = out_a_valid & out_a_ready;
  assign a_fire0     = in0_a_valid & in0_a_ready;
  assign a_fire1     = in1_a_valid & in1_a_ready;

  assign out_a_bits_opcode  = gnt ? in1_a_bits_opcode  : in0_a_bits_opcode;
  assign out_a_bits_param   = gnt ? in1_a_bits_param   : in0_a_bits_param;
  assign out_a_bits_size    = gnt ? in1_a_bits_size    : in0_a_bits_size;
  assign out_a_bits_source  = {gnt, (gnt ? in1_a_bits_source : in0_a_bits_source)};
  assign out_a_bits_address = gnt ? in1_a_bits_address : in0_a_bits_address;
  assign out_a_bits_mask    = gnt ? in1_a_bits_mask    : in0_a_bits_mask;
  assign out_a_bits_data    = gnt ? in1_a_bits_data    : in0_a_bits_data;
  assign out_a_bits_corrupt = 1'b0;

  // D responses are steered by the client tag in the top source bit.
  assign tgt         = out_d_bits_source[9];
  assign in0_d_valid = out_d_valid & ~tgt;
  assign in1_d_valid = out_d_valid &  tgt;
  assign out_d_ready = tgt ? in1_d_ready : in0_d_ready;
  assign d_fire0     = in0_d_valid & in0_d_ready;
  assign d_fire1     = in1_d_valid & in1_d_ready;

  assign in0_d_bits_opcode  = out_d_bits_opcode;
  assign in0_d_bits_param   = out_d_bits_param;
  assign in0_d_bits_size    = out_d_bits_size;
  assign in0_d_bits_source  = out_d_bits_source[8:0];
  assign in0_d_bits_sink    = out_d_bits_sink;
  assign in0_d_bits_denied  = out_d_bits_denied;
  assign in0_d_bits_data    = out_d_bits_data;
  assign in0_d_bits_corrupt = out_d_bits_corrupt;
  assign in1_d_bits_opcode  = out_d_bits_opcode;
  assign in1_d_bits_param   = out_d_bits_param;
  assign in1_d_bits_size    = out_d_bits_size;
  assign in1_d_bits_source  = out_d_bits_source[8:0];
  assign in1_d_bits_sink    = out_d_bits_sink;
  assign in1_d_bits_denied  = out_d_bits_denied;
  assign in1_d_bits_data    = out_d_bits_data;
  assign in1_d_bits_corrupt = out_d_bits_corrupt;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec)                          nxt = cnt + 1'b1;
    else if (dec && !inc && cnt != '0)        nxt = cnt - 1'b1;
    return nxt;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers; blocking here would create ordering races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= 1'b0;
      locked    <= 1'b0;
      lock_idx  <= 1'b0;
      inflight0 <= '0;
      inflight1 <= '0;
      err_q     <= 1'b0;
    end else begin
      if (a_fire) begin
        rr_ptr <= ~gnt;
        locked <= 1'b0;
      end else if (out_a_valid) begin
        locked   <= 1'b1;
        lock_idx <= gnt;
      end
      inflight0 <= next_cnt(inflight0, a_fire0, d_fire0);
      inflight1 <= next_cnt(inflight1, a_fire1, d_fire1);
      if ((d_fire0 && inflight0 == '0) || (d_fire1 && inflight1 == '0)) err_q <= 1'b1;
    end
  end

  assign idle             = ~locked & (inflight0 == '0) & (inflight1 == '0);
  assign err_unexpected_d = err_q;

endmodule

// File: doc/tl_a_client_arbiter.md
Name: tl_a_client_arbiter

Overview:
- Two-client TileLink-UL arbiter that shares one A/D channel pair between two requesters.
- Sits upstream of the A/D buffer stage that feeds the system bus.
- Round-robin arbitration on A with grant locking, per-client in-flight limits, source tagging, D-response routing by tag, and a drain/idle interface for quiesce control.

Parameters:
- MAX_INFLIGHT, 4: maximum outstanding A requests per client (1..15).
- CNT_W, 4: in-flight counter width; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- in{0,1}_a_valid  input  1 each  client A valid.
- in{0,1}_a_ready  output  1 each  client A ready.
- in{0,1}_a_bits_{opcode,param,size,source,address,mask,data}  input  3/3/2/9/32/8/64  client A payload.
- in{0,1}_d_ready  input  1 each  client D ready.
- in{0,1}_d_valid  output  1 each  client D valid.
- in{0,1}_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}  output  3/2/2/9/1/1/64/1  client D payload.
- out_a_ready  input  1  downstream A ready.
- out_a_valid  output  1  downstream A valid.
- out_a_bits_{opcode,param,size,source,address,mask,data,corrupt}  output  3/3/2/10/32/8/64/1  downstream A payload.
- out_d_valid  input  1  downstream D valid.
- out_d_ready  output  1  downstream D ready.
- out_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}  input  3/2/2/10/1/1/64/1  downstream D payload.
- drain  input  1  block new A grants while high.
- idle  output  1  no lock held and no requests outstanding.
- err_unexpected_d  output  1  sticky: D received for a client with zero outstanding requests.

Behaviour:
- State:
  - rr_ptr (1b, reset 0): client 0 has priority after reset.
  - locked (1b, reset 0) and lock_idx (1b, reset 0).
  - inflight0/inflight1 (CNT_W each, reset 0).
  - err flag (reset 0).
- Reset is asynchronous and active-low; all state clears immediately on assertion, including mid-transfer.
- Outputs during reset:
  - out_a_valid=0, in*_a_ready=0, err_unexpected_d=0, idle=1.
  - D outputs follow their inputs combinationally.
- Eligibility: elig_i = in_i_a_valid & (inflight_i < MAX_INFLIGHT) & (!drain | (locked & lock_idx==i)).
- Grant selection (combinational):
  - If locked: gnt=lock_idx.
  - Else if both eligible: gnt=rr_ptr.
  - Else gnt = whichever client is eligible.
  - If neither is eligible, no grant and out_a_valid=0.
- A channel:
  - out_a_valid = elig_gnt.
  - in_i_a_ready = out_a_ready & (gnt==i) & elig_i.
  - Payload is muxed from gnt.
  - out_a_bits_source = {gnt, in_gnt_source[8:0]}; out_a_bits_corrupt=0.
  - Latency: zero cycles, combinational passthrough.
- Lock: when out_a_valid & !out_a_ready, set locked=1 and lock_idx=gnt. The lock clears on A fire. The grant never switches while a beat is presented but not accepted. An active lock overrides drain.
- Round-robin: on A fire, rr_ptr <= ~gnt.
- D channel (combinational, zero latency):
  - tgt = out_d_bits_source[9].
  - in_i_d_valid = out_d_valid & (tgt==i).
  - out_d_ready = in_tgt_d_ready.
  - Payload is broadcast to both clients; in_i_d_bits_source = out_d_bits_source[8:0].
- Counters (one D per A, UL only):
  - inflight_i increments on A fire from i and decrements on D fire to i.
  - Simultaneous A fire and D fire on the same client leaves the counter unchanged.
  - Counters saturate at 0.
  - A D fire to client i with inflight_i==0 sets err_unexpected_d; it clears only on reset.
- idle = !locked & inflight0==0 & inflight1==0. It is combinational from registered state.
- Drain controller usage: assert drain, wait for idle=1.

Test Plan:
- Fairness: in0/in1 both valid continuously with sources 0x005/0x005, out_a_ready=1 -> out_a_bits_source alternates 0x005, 0x205, 0x005, 0x205..., starting with in0 after reset.
- Lock: in0 presented with out_a_ready=0 for 3 cycles while in1 valid -> out_a_valid stays 1 from in0, in1_a_ready=0. Raise ready -> in0 fires, then in1 is granted the next cycle.
- Limit (MAX_INFLIGHT=2): in0 fires twice with no D -> in0_a_ready=0 and in1 is still served. A D with source 0x001 fires to in0 -> inflight0=1 and in0 is granted the next cycle.
- Simultaneous: in1 A fire and a D fire with source 0x2xx in the same cycle -> inflight1 unchanged. The D is routed only to in1_d_valid, and out_d_ready tracks in1_d_ready.
- Drain: 2 outstanding on in0, drain=1, in0/in1 valid -> no new A grants, idle=0. Return 2 D beats -> idle=1 in the cycle after the second D fire.
- Error/reset: a D fire to a client with inflight=0 -> err_unexpected_d=1 and held. Assert reset low mid-lock -> out_a_valid=0, err=0, idle=1 immediately without waiting for a clock edge.
